lfsr_random_timer: RTL and testbench

Random-interval pulse generator that sits directly downstream of the team's LFSR pseudo-random source. It drives the LFSR's enable input with a one-cycle step request and takes the LFSR's parallel output one cycle later. It turns that value into a bounded countdown and emits a one-cycle pulse when the countdown expires. Typical uses are randomized test stimulus, back-off timers and blink/jitter generators.

---
 rtl/lfsr_random_timer.sv | 113 +++++++++++
 tb/tb_lfsr_random_timer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_random_timer.sv
// rtl/lfsr_random_timer.sv - random-interval pulse timer fed by an upstream LFSR
module lfsr_random_timer #(
  parameter int unsigned NUM_BITS  = 16,
  parameter logic [31:0] MIN_DELAY = 32'd16,
  parameter int unsigned MASK_BITS = 8
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Start,
  input  logic [NUM_BITS-1:0] i_LFSR_Data,
  output logic                o_LFSR_Enable,
  output logic                o_Pulse,
  output logic                o_Busy,
  output logic [31:0]         o_Delay,
  output logic [15:0]         o_Event_Count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_LOAD,
    S_COUNT,
    S_FIRE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [31:0] delay_q, delay_d;
  logic [15:0] events_q, events_d;
  logic        enable_q, enable_d;
  logic        pulse_q, pulse_d;
  logic        busy_q, busy_d;
  logic [31:0] sum;
  logic        unused_lfsr_bits;

  // Masked LFSR bits are zero-extended; MASK_BITS <= 24 keeps them inside 32 bits.
  always_comb begin
    sum = MIN_DELAY + {{(32 - MASK_BITS){1'b0}}, i_LFSR_Data[MASK_BITS-1:0]};
  end

  assign unused_lfsr_bits = ^i_LFSR_Data;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    delay_d  = delay_q;
    events_d = events_q;
    case (state_q)
      S_IDLE: begin
        if (i_Start) state_d = S_STEP;
      end
      S_STEP: begin
        state_d = i_Start ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        if (!i_Start) begin
          state_d = S_IDLE;
        end else begin
          delay_d = (sum == 32'd0) ? 32'd1 : sum;
          count_d = delay_d;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!i_Start) begin
          state_d = S_IDLE;
        end else if (count_q == 32'd1) begin
          state_d = S_FIRE;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      S_FIRE: begin
        // FIRE always completes; i_Start only chooses where to go next.
        events_d = events_q + 16'd1;
        state_d  = i_Start ? S_STEP : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    enable_d = (state_d == S_STEP);
    pulse_d  = (state_d == S_FIRE);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state_q  <= S_IDLE;
      count_q  <= 32'd0;
      delay_q  <= 32'd0;
      events_q <= 16'd0;
      enable_q <= 1'b0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      delay_q  <= delay_d;
      events_q <= events_d;
      enable_q <= enable_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
    end
  end

  assign o_LFSR_Enable = enable_q;
  assign o_Pulse       = pulse_q;
  assign o_Busy        = busy_q;
  assign o_Delay       = delay_q;
  assign o_Event_Count = events_q;

endmodule

// File: tb/tb_lfsr_random_timer.sv
// tb/tb_lfsr_random_timer.sv - self-checking bench for lfsr_random_timer
module tb_lfsr_random_timer;

  localparam logic [31:0] A_MIN = 32'd16;
  localparam logic [31:0] Z_MIN = 32'd0;
  localparam logic [31:0] L_MIN = 32'd16;
  localparam logic [31:0] W_MIN = 32'd1;
  localparam int A_MASK = 4;
  localparam int Z_MASK = 8;
  localparam int L_MASK = 8;
  localparam int W_MASK = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_rst, a_start, a_en, a_pulse, a_busy;
  logic [15:0] a_data, a_cnt;
  logic [31:0] a_delay;

  logic        rst_b;
  logic        z_start, z_en, z_pulse, z_busy;
  logic [15:0] z_data, z_cnt;
  logic [31:0] z_delay;
  logic        l_start, l_en, l_pulse, l_busy;
  logic [15:0] lfsr_q, l_cnt;
  logic [31:0] l_delay;
  logic        w_start, w_en, w_pulse, w_busy;
  logic [15:0] w_data, w_cnt;
  logic [31:0] w_delay;

  lfsr_random_timer #(.NUM_BITS(16), .MIN_DELAY(A_MIN), .MASK_BITS(A_MASK)) u_fixed (
    .i_Clk(clk), .i_Rst(a_rst), .i_Start(a_start), .i_LFSR_Data(a_data),
    .o_LFSR_Enable(a_en), .o_Pulse(a_pulse), .o_Busy(a_busy),
    .o_Delay(a_delay), .o_Event_Count(a_cnt)
  );

  lfsr_random_timer #(.NUM_BITS(16), .MIN_DELAY(Z_MIN), .MASK_BITS(Z_MASK)) u_zero (
    .i_Clk(clk), .i_Rst(rst_b), .i_Start(z_start), .i_LFSR_Data(z_data),
    .o_LFSR_Enable(z_en), .o_Pulse(z_pulse), .o_Busy(z_busy),
    .o_Delay(z_delay), .o_Event_Count(z_cnt)
  );

  lfsr_random_timer #(.NUM_BITS(16), .MIN_DELAY(L_MIN), .MASK_BITS(L_MASK)) u_lfsr (
    .i_Clk(clk), .i_Rst(rst_b), .i_Start(l_start), .i_LFSR_Data(lfsr_q),
    .o_LFSR_Enable(l_en), .o_Pulse(l_pulse), .o_Busy(l_busy),
    .o_Delay(l_delay), .o_Event_Count(l_cnt)
  );

  lfsr_random_timer #(.NUM_BITS(16), .MIN_DELAY(W_MIN), .MASK_BITS(W_MASK)) u_wrap (
    .i_Clk(clk), .i_Rst(rst_b), .i_Start(w_start), .i_LFSR_Data(w_data),
    .o_LFSR_Enable(w_en), .o_Pulse(w_pulse), .o_Busy(w_busy),
    .o_Delay(w_delay), .o_Event_Count(w_cnt)
  );

  // Upstream 16-bit Fibonacci LFSR (taps 16,14,13,11), seed reloaded on reset.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_b) lfsr_q <= 16'hACE1;
    else if (l_en) lfsr_q <= lfsr_next(lfsr_q);
  end

  function automatic bit range_ok(input logic [31:0] mn, input int mask);
    return (64'(mn) + (64'd1 << mask) - 64'd1) < 64'h1_0000_0000;
  endfunction

  initial begin
    assert (range_ok(A_MIN, A_MASK) && range_ok(Z_MIN, Z_MASK) &&
            range_ok(L_MIN, L_MASK) && range_ok(W_MIN, W_MASK))
      else $fatal(1, "FAIL param_range: MIN_DELAY + 2^MASK_BITS - 1 does not fit 32 bits");
  end

  task automatic test_reset();
    a_rst = 1'b0; rst_b = 1'b0; a_start = 1'b1; a_data = 16'h00A5;
    z_start = 1'b0; z_data = 16'hFF00; l_start = 1'b0; w_start = 1'b0; w_data = 16'h1234;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({a_en, a_pulse, a_busy, a_delay, a_cnt} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: en=%b pulse=%b busy=%b delay=%0d count=%0d, required all 0",
                 a_en, a_pulse, a_busy, a_delay, a_cnt);
      end
    end
    a_rst = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if (a_en !== 1'b1 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_step: en=%b busy=%b, required en=1 busy=1", a_en, a_busy);
    end
    a_start = 1'b0;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_en !== 1'b0 || a_delay !== 32'd0) begin
      errors++;
      $display("FAIL reset_step_abort: busy=%b en=%b delay=%0d, required 0 0 0", a_busy, a_en, a_delay);
    end
  endtask

  task automatic test_fixed_data();
    int  exp_q[$];
    int  exp_cnt;
    bit  exp_pulse;
    exp_cnt = 0;
    for (int p = 1; p <= 3; p++) exp_q.push_back(24 * p);
    a_start = 1'b1;
    for (int k = 1; k <= 74; k++) begin
      @(negedge clk);
      exp_pulse = (exp_q.size() > 0) && (exp_q[0] == k);
      checks++;
      if (a_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL fixed_pulse: cycle %0d got %b required %b", k, a_pulse, exp_pulse);
      end
      if (exp_pulse) void'(exp_q.pop_front());
      checks++;
      if (a_en !== (k % 24 == 1)) begin
        errors++;
        $display("FAIL fixed_enable: cycle %0d got %b required %b", k, a_en, (k % 24 == 1));
      end
      checks++;
      if (a_delay !== ((k >= 3) ? 32'd21 : 32'd0)) begin
        errors++;
        $display("FAIL fixed_delay: cycle %0d got %0d required %0d", k, a_delay, (k >= 3) ? 21 : 0);
      end
      checks++;
      if (a_cnt !== exp_cnt[15:0]) begin
        errors++;
        $display("FAIL fixed_count: cycle %0d got %0d required %0d", k, a_cnt, exp_cnt);
      end
      checks++;
      if (a_busy !== 1'b1) begin
        errors++;
        $display("FAIL fixed_busy: cycle %0d got %b required 1", k, a_busy);
      end
      if (exp_pulse) exp_cnt++;
    end
    a_start = 1'b0;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_delay !== 32'd21 || a_cnt !== 16'd3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL fixed_load_abort: busy=%b delay=%0d count=%0d pending=%0d, required 0 21 3 0",
               a_busy, a_delay, a_cnt, exp_q.size());
    end
  endtask

  task automatic test_abort();
    a_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b1 || a_pulse !== 1'b0 || a_en !== (k == 1)) begin
        errors++;
        $display("FAIL abort_run: cycle %0d busy=%b pulse=%b en=%b, required 1 0 %b",
                 k, a_busy, a_pulse, a_en, (k == 1));
      end
    end
    a_start = 1'b0;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_pulse !== 1'b0 || a_en !== 1'b0 || a_cnt !== 16'd3 || a_delay !== 32'd21) begin
      errors++;
      $display("FAIL abort_idle: busy=%b pulse=%b en=%b count=%0d delay=%0d, required 0 0 0 3 21",
               a_busy, a_pulse, a_en, a_cnt, a_delay);
    end
    for (int k = 12; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (a_pulse !== 1'b0 || a_en !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet: cycle %0d pulse=%b en=%b, required 0 0", k, a_pulse, a_en);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    a_start = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (a_busy !== 1'b1 || a_delay !== 32'd21) begin
      errors++;
      $display("FAIL midrst_running: busy=%b delay=%0d, required 1 21", a_busy, a_delay);
    end
    a_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_en, a_pulse, a_busy, a_delay, a_cnt} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: en=%b pulse=%b busy=%b delay=%0d count=%0d, required all 0",
               a_en, a_pulse, a_busy, a_delay, a_cnt);
    end
    a_rst = 1'b1; a_start = 1'b0;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_en !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: busy=%b en=%b, required 0 0", a_busy, a_en);
    end
  endtask

  task automatic test_zero_clamp();
    int exp_cnt;
    exp_cnt = 0;
    z_start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (z_pulse !== (k % 4 == 0) || z_en !== (k % 4 == 1) ||
          z_delay !== ((k >= 3) ? 32'd1 : 32'd0) || z_cnt !== exp_cnt[15:0]) begin
        errors++;
        $display("FAIL zero_clamp: cycle %0d pulse=%b en=%b delay=%0d count=%0d, required %b %b %0d %0d",
                 k, z_pulse, z_en, z_delay, z_cnt, (k % 4 == 0), (k % 4 == 1), (k >= 3) ? 1 : 0, exp_cnt);
      end
      if (k % 4 == 0) exp_cnt++;
    end
    z_start = 1'b0;
    @(negedge clk);
    checks++;
    if (z_busy !== 1'b0 || z_cnt !== 16'd5) begin
      errors++;
      $display("FAIL zero_fire_complete: busy=%b count=%0d, required 0 5", z_busy, z_cnt);
    end
  endtask

  task automatic test_lfsr_integration();
    logic [15:0] g;
    int exp_q[$];
    int last, pulses, enables, k, d, err0;
    g = 16'hACE1; last = 0; pulses = 0; enables = 0; k = 0; err0 = errors;
    l_start = 1'b1;
    while (pulses < 200 && k < 60000 && errors - err0 < 20) begin
      @(negedge clk);
      k++;
      if (l_en === 1'b1) begin
        enables++;
        g = lfsr_next(g);
        exp_q.push_back(int'(L_MIN) + int'(g[7:0]));
      end
      if (l_pulse === 1'b1) begin
        pulses++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL lfsr_unexpected_pulse: cycle %0d pulse with no step issued, required none", k);
        end else begin
          d = exp_q.pop_front();
          if (k - last != d + 3) begin
            errors++;
            $display("FAIL lfsr_interval: pulse %0d got %0d cycles required %0d", pulses, k - last, d + 3);
          end
          checks++;
          if (l_delay !== 32'(d)) begin
            errors++;
            $display("FAIL lfsr_delay: pulse %0d got %0d required %0d", pulses, l_delay, d);
          end
        end
        last = k;
        if (pulses == 200) l_start = 1'b0;
      end
    end
    checks++;
    if (pulses != 200) begin
      errors++;
      $display("FAIL lfsr_pulse_total: got %0d pulses in %0d cycles required 200", pulses, k);
    end
    @(negedge clk);
    checks++;
    if (l_busy !== 1'b0 || enables != pulses || l_cnt !== 16'(pulses)) begin
      errors++;
      $display("FAIL lfsr_totals: busy=%b enables=%0d count=%0d, required 0 %0d %0d",
               l_busy, enables, l_cnt, pulses, pulses);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_cnt;
    int pulses, k, err0;
    exp_cnt = 16'd0; pulses = 0; k = 0; err0 = errors;
    w_start = 1'b1;
    while (pulses < 65536 && k < 270000 && errors - err0 < 20) begin
      @(negedge clk);
      k++;
      checks++;
      if (w_pulse !== (k % 4 == 0)) begin
        errors++;
        $display("FAIL wrap_pulse: cycle %0d got %b required %b", k, w_pulse, (k % 4 == 0));
      end
      checks++;
      if (w_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL wrap_count: cycle %0d got %h required %h", k, w_cnt, exp_cnt);
      end
      if (k == 4 * 65536) begin
        checks++;
        if (w_cnt !== 16'hFFFF) begin
          errors++;
          $display("FAIL wrap_ffff: got %h required ffff", w_cnt);
        end
      end
      if (k % 4 == 0) begin
        exp_cnt = exp_cnt + 16'd1;
        pulses++;
        if (pulses == 65536) w_start = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (w_cnt !== 16'h0000 || w_busy !== 1'b0 || w_pulse !== 1'b0 || pulses != 65536) begin
      errors++;
      $display("FAIL wrap_final: count=%h busy=%b pulse=%b pulses=%0d, required 0000 0 0 65536",
               w_cnt, w_busy, w_pulse, pulses);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_data();
    test_abort();
    test_reset_mid_run();
    test_zero_clamp();
    test_lfsr_integration();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
